// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card lookup, PIN retries with account lockout,
// inactivity timeouts and session hand-off to the transaction logic.
module atm_session_ctrl #(
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int NUM_ACC     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_insert,
  input  logic [3:0]  acc_num_in,
  input  logic [15:0] pin_in,
  input  logic        pin_valid,
  input  logic        cancel,
  input  logic        session_done,
  output logic [3:0]  auth_acc_num,
  output logic [15:0] auth_pin,
  input  logic        auth_found,
  input  logic        auth_ok,
  input  logic [3:0]  auth_index,
  output logic        session_active,
  output logic [3:0]  acc_index,
  output logic        card_eject,
  output logic [2:0]  err_code,
  output logic [2:0]  tries_left
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_WAIT_PIN = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_SESSION  = 3'd4;
  localparam logic [2:0] S_EJECT    = 3'd5;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_NOTFND  = 3'd1;
  localparam logic [2:0] ERR_BADPIN  = 3'd2;
  localparam logic [2:0] ERR_LOCKED  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_CANCEL  = 3'd5;

  localparam logic [2:0]  TRIES_INIT = 3'(MAX_TRIES);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYC - 1);

  logic [2:0]         state;
  logic [15:0]        timer;
  logic [15:0]        timer_inc;
  logic               timed_out;
  logic [NUM_ACC-1:0] lock_mask;
  logic [3:0]         idx_q;

  // Lock-mask access by loop so indices at or beyond NUM_ACC never alias a bit.
  function automatic logic idx_valid(input logic [3:0] idx);
    idx_valid = 1'b0;
    for (int i = 0; i < NUM_ACC; i++)
      if (idx == 4'(i)) idx_valid = 1'b1;
  endfunction

  function automatic logic is_locked(input logic [NUM_ACC-1:0] mask,
                                     input logic [3:0] idx);
    is_locked = 1'b0;
    for (int i = 0; i < NUM_ACC; i++)
      if (idx == 4'(i)) is_locked = mask[i];
  endfunction

  function automatic logic [NUM_ACC-1:0] lock_bit(input logic [3:0] idx);
    lock_bit = '0;
    for (int i = 0; i < NUM_ACC; i++)
      if (idx == 4'(i)) lock_bit[i] = 1'b1;
  endfunction

  assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;
  assign timed_out = (timer == TMO_LAST);

  assign session_active = (state == S_SESSION);
  assign card_eject     = (state == S_EJECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      lock_mask    <= '0;
      idx_q        <= '0;
      auth_acc_num <= '0;
      auth_pin     <= '0;
      acc_index    <= '0;
      err_code     <= ERR_NONE;
      tries_left   <= TRIES_INIT;
    end else begin
      // Timer restarts on every transition; only the two idle-wait states let it run.
      timer <= '0;
      case (state)
        S_IDLE: begin
          if (card_insert) begin
            auth_acc_num <= acc_num_in;
            err_code     <= ERR_NONE;
            tries_left   <= TRIES_INIT;
            state        <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!auth_found || !idx_valid(auth_index)) begin
            err_code <= ERR_NOTFND;
            state    <= S_EJECT;
          end else if (is_locked(lock_mask, auth_index)) begin
            err_code <= ERR_LOCKED;
            state    <= S_EJECT;
          end else begin
            idx_q <= auth_index;
            state <= S_WAIT_PIN;
          end
        end
        S_WAIT_PIN: begin
          if (cancel) begin
            err_code <= ERR_CANCEL;
            state    <= S_EJECT;
          end else if (pin_valid) begin
            auth_pin <= pin_in;
            state    <= S_CHECK;
          end else if (timed_out) begin
            err_code <= ERR_TIMEOUT;
            state    <= S_EJECT;
          end else begin
            timer <= timer_inc;
          end
        end
        S_CHECK: begin
          if (auth_ok) begin
            err_code   <= ERR_NONE;
            acc_index  <= idx_q;
            tries_left <= TRIES_INIT;
            state      <= S_SESSION;
          end else if (tries_left > 3'd1) begin
            tries_left <= tries_left - 3'd1;
            err_code   <= ERR_BADPIN;
            state      <= S_WAIT_PIN;
          end else begin
            lock_mask  <= lock_mask | lock_bit(idx_q);
            tries_left <= 3'd0;
            err_code   <= ERR_LOCKED;
            state      <= S_EJECT;
          end
        end
        S_SESSION: begin
          if (cancel) begin
            err_code <= ERR_CANCEL;
            state    <= S_EJECT;
          end else if (session_done) begin
            err_code <= ERR_NONE;
            state    <= S_EJECT;
          end else if (timed_out) begin
            err_code <= ERR_TIMEOUT;
            state    <= S_EJECT;
          end else if (!(pin_valid || card_insert)) begin
            timer <= timer_inc;
          end
        end
        S_EJECT: begin
          auth_pin <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scenario bench for atm_session_ctrl with a behavioural account authenticator
// and a queue of expected output snapshots.
module tb_atm_session_ctrl;

  localparam int MAX_TRIES   = 3;
  localparam int TIMEOUT_CYC = 20;
  localparam int NUM_ACC     = 10;

  logic        clk;
  logic        rst;
  logic        card_insert;
  logic [3:0]  acc_num_in;
  logic [15:0] pin_in;
  logic        pin_valid;
  logic        cancel;
  logic        session_done;
  logic [3:0]  auth_acc_num;
  logic [15:0] auth_pin;
  logic        auth_found;
  logic        auth_ok;
  logic [3:0]  auth_index;
  logic        session_active;
  logic [3:0]  acc_index;
  logic        card_eject;
  logic [2:0]  err_code;
  logic [2:0]  tries_left;

  logic        force_bad_idx;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       sa;
    logic       ej;
    logic [2:0] err;
    logic [2:0] tries;
    logic [3:0] idx;
  } obs_t;

  obs_t  sb[$];
  string sb_nm[$];
  obs_t  exp_o;
  obs_t  got_o;
  string nm;

  atm_session_ctrl #(
    .MAX_TRIES(MAX_TRIES),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .NUM_ACC(NUM_ACC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .card_insert(card_insert),
    .acc_num_in(acc_num_in),
    .pin_in(pin_in),
    .pin_valid(pin_valid),
    .cancel(cancel),
    .session_done(session_done),
    .auth_acc_num(auth_acc_num),
    .auth_pin(auth_pin),
    .auth_found(auth_found),
    .auth_ok(auth_ok),
    .auth_index(auth_index),
    .session_active(session_active),
    .acc_index(acc_index),
    .card_eject(card_eject),
    .err_code(err_code),
    .tries_left(tries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accounts 1..10 live at index acc-1 with PIN 1234 + 1111*(acc-1).
  function automatic logic [15:0] pin_of(input logic [3:0] acc);
    return 16'd1234 + 16'(acc - 4'd1) * 16'd1111;
  endfunction

  always_comb begin
    auth_found = (auth_acc_num >= 4'd1) && (auth_acc_num <= 4'd10);
    auth_index = auth_acc_num - 4'd1;
    auth_ok    = auth_found && (auth_pin == pin_of(auth_acc_num));
    if (force_bad_idx) begin
      auth_found = 1'b1;
      auth_index = 4'd12;
      auth_ok    = 1'b0;
    end
  end

  function automatic obs_t mk(input logic sa, input logic ej, input logic [2:0] err,
                              input logic [2:0] tries, input logic [3:0] idx);
    obs_t o;
    o.sa = sa; o.ej = ej; o.err = err; o.tries = tries; o.idx = idx;
    return o;
  endfunction

  function automatic obs_t cur();
    return mk(session_active, card_eject, err_code, tries_left,
              session_active ? acc_index : 4'd0);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("sa=%0b ej=%0b err=%0d tries=%0d idx=%0d", o.sa, o.ej, o.err, o.tries, o.idx);
  endfunction

  task automatic push(input string n, input obs_t o);
    sb.push_back(o);
    sb_nm.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_insert(input logic [3:0] a);
    acc_num_in = a; card_insert = 1'b1;
    @(posedge clk); #1;
    card_insert = 1'b0;
  endtask

  task automatic pulse_pin(input logic [15:0] p);
    pin_in = p; pin_valid = 1'b1;
    @(posedge clk); #1;
    pin_valid = 1'b0;
  endtask

  // lat counts rising edges from the one that sampled the last stimulus pulse.
  task automatic wait_out(input int budget, input bit only_eject, output int lat);
    lat = 1;
    repeat (budget) begin
      @(negedge clk);
      if (card_eject || (!only_eject && session_active)) return;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    errors++;
    $display("FAIL wait_out: no output within %0d cycles", budget);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push("reset_outputs", mk(1'b0, 1'b0, 3'd0, 3'(MAX_TRIES), 4'd0));
    @(negedge clk);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    checks++;
    if (auth_acc_num !== 4'd0) begin errors++; $display("FAIL reset_acc_num got %0d want 0", auth_acc_num); end
    checks++;
    if (auth_pin !== 16'd0) begin errors++; $display("FAIL reset_pin got %0d want 0", auth_pin); end
  endtask

  task automatic test_good_session();
    int lat;
    pulse_insert(4'd1);
    tick();
    push("good_session", mk(1'b1, 1'b0, 3'd0, 3'd3, 4'd0));
    pulse_pin(16'd1234);
    wait_out(10, 1'b0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL pin_to_session_latency got %0d want 2", lat); end
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    push("done_eject", mk(1'b0, 1'b1, 3'd0, 3'd3, 4'd0));
    session_done = 1'b1;
    @(posedge clk); #1;
    session_done = 1'b0;
    wait_out(5, 1'b1, lat);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    tick();
    push("idle_after_eject", mk(1'b0, 1'b0, 3'd0, 3'd3, 4'd0));
    @(negedge clk);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    checks++;
    if (auth_pin !== 16'd0) begin errors++; $display("FAIL pin_cleared got %0d want 0", auth_pin); end
  endtask

  task automatic test_not_found();
    int lat;
    push("not_found_eject", mk(1'b0, 1'b1, 3'd1, 3'd3, 4'd0));
    pulse_insert(4'd11);
    wait_out(10, 1'b1, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL insert_to_eject_latency got %0d want 2", lat); end
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    tick();
    push("pin_ignored_idle", mk(1'b0, 1'b0, 3'd1, 3'd3, 4'd0));
    pulse_pin(16'd1234);
    @(negedge clk);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    force_bad_idx = 1'b1;
    push("index_out_of_range", mk(1'b0, 1'b1, 3'd1, 3'd3, 4'd0));
    pulse_insert(4'd7);
    wait_out(10, 1'b1, lat);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    force_bad_idx = 1'b0;
    tick();
  endtask

  task automatic test_lockout();
    int lat;
    pulse_insert(4'd3);
    tick();
    push("bad_pin_1", mk(1'b0, 1'b0, 3'd2, 3'd2, 4'd0));
    push("bad_pin_2", mk(1'b0, 1'b0, 3'd2, 3'd1, 4'd0));
    pulse_pin(16'd1111);
    tick();
    @(negedge clk);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    pulse_pin(16'd2222);
    tick();
    @(negedge clk);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    push("lock_eject", mk(1'b0, 1'b1, 3'd3, 3'd0, 4'd0));
    pulse_pin(16'd3333);
    wait_out(10, 1'b1, lat);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    tick();
    push("locked_at_lookup", mk(1'b0, 1'b1, 3'd3, 3'd3, 4'd0));
    pin_in = 16'd3456;
    pulse_insert(4'd3);
    wait_out(10, 1'b1, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL locked_eject_latency got %0d want 2", lat); end
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    tick();
  endtask

  task automatic test_retry_and_timeouts();
    int lat;
    int n;
    pulse_insert(4'd2);
    tick();
    push("retry_bad", mk(1'b0, 1'b0, 3'd2, 3'd2, 4'd0));
    pulse_pin(16'd1111);
    tick();
    @(negedge clk);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    push("retry_good", mk(1'b1, 1'b0, 3'd0, 3'd3, 4'd1));
    pulse_pin(16'd2345);
    wait_out(10, 1'b0, lat);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    push("session_timeout", mk(1'b0, 1'b1, 3'd4, 3'd3, 4'd0));
    n = 0;
    while (n < TIMEOUT_CYC + 10) begin
      @(posedge clk); #1;
      n++;
      if (card_eject) break;
    end
    checks++;
    if (n !== TIMEOUT_CYC) begin errors++; $display("FAIL session_timeout_cycles got %0d want %0d", n, TIMEOUT_CYC); end
    @(negedge clk);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    tick();
    push("wait_pin_timeout", mk(1'b0, 1'b1, 3'd4, 3'd3, 4'd0));
    pulse_insert(4'd4);
    tick();
    n = 0;
    while (n < TIMEOUT_CYC + 10) begin
      @(posedge clk); #1;
      n++;
      if (card_eject) break;
    end
    checks++;
    if (n !== TIMEOUT_CYC) begin errors++; $display("FAIL wait_pin_timeout_cycles got %0d want %0d", n, TIMEOUT_CYC); end
    @(negedge clk);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    tick();
  endtask

  task automatic test_cancel_priority();
    int lat;
    pulse_insert(4'd5);
    tick();
    push("cancel_over_pin", mk(1'b0, 1'b1, 3'd5, 3'd3, 4'd0));
    cancel = 1'b1; pin_in = 16'd5678; pin_valid = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0; pin_valid = 1'b0;
    wait_out(5, 1'b1, lat);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    checks++;
    if (auth_pin !== 16'd0) begin errors++; $display("FAIL pin_not_latched got %0d want 0", auth_pin); end
    tick();
    pulse_insert(4'd5);
    tick();
    push("session_acc5", mk(1'b1, 1'b0, 3'd0, 3'd3, 4'd4));
    push("cancel_over_done", mk(1'b0, 1'b1, 3'd5, 3'd3, 4'd0));
    pulse_pin(16'd5678);
    wait_out(10, 1'b0, lat);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    cancel = 1'b1; session_done = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0; session_done = 1'b0;
    wait_out(5, 1'b1, lat);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    tick();
  endtask

  task automatic test_reset_mid_session();
    int lat;
    int ejects;
    pulse_insert(4'd1);
    tick();
    push("pre_reset_session", mk(1'b1, 1'b0, 3'd0, 3'd3, 4'd0));
    pulse_pin(16'd1234);
    wait_out(10, 1'b0, lat);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    push("after_mid_reset", mk(1'b0, 1'b0, 3'd0, 3'(MAX_TRIES), 4'd0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ejects = 0;
    @(negedge clk);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    if (card_eject) ejects++;
    repeat (3) begin
      @(negedge clk);
      if (card_eject) ejects++;
    end
    checks++;
    if (ejects !== 0) begin errors++; $display("FAIL no_eject_on_reset got %0d pulses want 0", ejects); end
    #1;
    pulse_insert(4'd3);
    tick();
    push("acc3_unlocked", mk(1'b1, 1'b0, 3'd0, 3'd3, 4'd2));
    pulse_pin(16'd3456);
    wait_out(10, 1'b0, lat);
    exp_o = sb.pop_front(); nm = sb_nm.pop_front(); got_o = cur(); checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(got_o), fmt(exp_o)); end
    session_done = 1'b1;
    @(posedge clk); #1;
    session_done = 1'b0;
    wait_out(5, 1'b1, lat);
    tick();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drained got %0d left want 0", sb.size()); end
  endtask

  initial begin
    rst = 1'b1; card_insert = 1'b0; acc_num_in = '0; pin_in = '0;
    pin_valid = 1'b0; cancel = 1'b0; session_done = 1'b0; force_bad_idx = 1'b0;
    test_reset();
    test_good_session();
    test_not_found();
    test_lockout();
    test_retry_and_timeouts();
    test_cancel_priority();
    test_reset_mid_session();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
